stream_filter_feeder: RTL and testbench
=======================================

# stream_filter_feeder

Initiator-side companion to the streaming 3x3 filter. It takes a frame descriptor (row length, row count, nine kernel coefficients, rescale shift/head) on a start pulse. It issues the filter's configuration writes on the `cfg_data`/`cfg_addr`/`cfg_valid` bus, then paces an upstream ready/valid pixel source into the filter's `image`/`image_val` input, one frame at a time. It sits between the host/DMA side and the filter wrapper.

## Interface
- `CFG_DWIDTH`, 32, config bus data width
- `CFG_AWIDTH`, 5, config bus address width
- `MEM_AWIDTH`, 12, width of row-length field (matches filter delay-line addressing)
- `IMG_WIDTH`, 16, pixel width
- `KER_WIDTH`, 16, kernel coefficient width (signed)
- `KER_NB`, 9, number of coefficients per frame
- `SETTLE`, 4, idle cycles between last config write and first pixel (>=1)
- `ROW_GAP`, 2, cycles `up_rdy` is held low between rows (0 allowed)

Ports:
- `clk` in 1, clock
- `rst_n` in 1, reset; **asynchronous, active-low**, one clock domain
- `start` in 1, single-cycle request; sampled only in IDLE
- `frm_row_len` in MEM_AWIDTH, pixels per row
- `frm_rows` in 16, rows per frame
- `frm_kernel` in KER_NB*KER_WIDTH, coefficient k at bits [k*KER_WIDTH +: KER_WIDTH]
- `frm_shift` in 8, rescale shift
- `frm_head` in 8, rescale head
- `up_data` in IMG_WIDTH, upstream pixel
- `up_val` in 1, upstream valid
- `up_rdy` out 1, upstream ready
- `cfg_data` out CFG_DWIDTH, config write data
- `cfg_addr` out CFG_AWIDTH, config write address
- `cfg_valid` out 1, config write strobe
- `image` out IMG_WIDTH, pixel to filter
- `image_val` out 1, pixel valid to filter
- `busy` out 1, high from cycle after accepted start until done
- `done` out 1, one-cycle frame-complete pulse

## Operation
- Reset: all outputs 0; FSM to IDLE; counters 0.
- Reset asserted mid-frame: same as reset. No partial writes or pixels emitted after release. `done` is not pulsed.
- IDLE: on `start`, latch all `frm_*` inputs, then go to CFG_W. `start` is ignored in any other state.
- CFG_W: one write, addr 1, data = row_len zero-extended.
- CFG_K: KER_NB writes, addr 2, coefficients k=0..KER_NB-1 in order, one per cycle, each sign-extended to CFG_DWIDTH.
- CFG_R: one write, addr 3, data = {zeros, shift[15:8], head[7:0]}.
- `cfg_data`/`cfg_addr` are 0 whenever `cfg_valid` is low.
- SETTLE: SETTLE cycles with no strobes.
- STREAM:
  - `up_rdy` is high.
  - Transfer = `up_val & up_rdy`.
  - Column counter counts 0..row_len-1. At a row's last transfer, the row counter increments.
  - If rows remain, go to GAP: `up_rdy` low for ROW_GAP cycles, then back to STREAM.
  - After the final row's last transfer, go to DONE.
- Each transfer produces `image` = `up_data` and `image_val` = 1 on the next cycle. Otherwise `image_val` = 0 and `image` holds 0.
- `up_val` low stalls the counters; no timeout.
- DONE: pulse `done` for one cycle, drop `busy`, return to IDLE.
- Row length 0 or rows 0: config is still written; STREAM is skipped; go SETTLE then DONE.
- Counters are sized MEM_AWIDTH (column) and 16 (row); no wrap occurs within legal values.

## Timing
- `start` sampled at cycle 0. `busy` = 1 from cycle 1.
- Config writes occur on cycles 1..KER_NB+2: 11 writes for default parameters, back-to-back, all outputs registered.
- SETTLE covers cycles KER_NB+3 .. KER_NB+2+SETTLE.
- `up_rdy` first high at cycle KER_NB+3+SETTLE, which is cycle 16 for default parameters.
- Pixel latency upstream to filter: 1 cycle.
- Last pixel transferred at cycle t: `image_val` = 1 at t+1, `up_rdy` = 0 at t+1, `done` = 1 at t+1, `busy` = 0 at t+2. A new `start` is accepted from t+2.
- GAP: a row's last transfer at cycle t gives `up_rdy` = 0 on cycles t+1..t+ROW_GAP and 1 at t+ROW_GAP+1. If ROW_GAP = 0, `up_rdy` stays high.
- Degenerate frame: `done` on the cycle after SETTLE ends.

## Test plan
- **Default frame.** row_len=4, rows=3, kernel k=1..9, shift=8, head=0, `up_val` held 1.
  - Expect 11 config writes on cycles 1..11: (1,4), (2,1)..(2,9), (3,0x0800).
  - Expect 12 `image_val` pulses in 3 bursts of 4, separated by 2-cycle gaps, and `done` coinciding with the 12th `image_val`.
- **Negative coefficient.** k0=16'hFFFE: expect `cfg_data`=32'hFFFFFFFE on the first addr-2 write.
- **Stalling source.** `up_val` toggles 1,0,1,0: expect exactly row_len*rows pixels out, in order, each one cycle after its transfer, and no extra `image_val`.
- **Ignored start.** `start` reasserted while busy: expect no effect on the write count or pixel count.
- **Degenerate frame.** row_len=0: expect 11 writes, no `up_rdy`, and `done` at cycle 16.
- **Reset mid-frame.** `rst_n` low during CFG_K and again during STREAM: expect all outputs 0 immediately (asynchronous), no `done`, and a clean full frame on the next `start`.

Source files
------------

// File: rtl/stream_filter_feeder.sv
`timescale 1ns/1ps
// stream_filter_feeder: latches a frame descriptor on start, then writes the
// filter configuration (row length, kernel, rescale). After a settle delay it
// paces an upstream ready/valid pixel source into the filter, row by row.
module stream_filter_feeder #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int MEM_AWIDTH = 12,
  parameter int IMG_WIDTH  = 16,
  parameter int KER_WIDTH  = 16,
  parameter int KER_NB     = 9,
  parameter int SETTLE     = 4,
  parameter int ROW_GAP    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [MEM_AWIDTH-1:0]       frm_row_len,
  input  logic [15:0]                 frm_rows,
  input  logic [KER_NB*KER_WIDTH-1:0] frm_kernel,
  input  logic [7:0]                  frm_shift,
  input  logic [7:0]                  frm_head,
  input  logic [IMG_WIDTH-1:0]        up_data,
  input  logic                        up_val,
  output logic                        up_rdy,
  output logic [CFG_DWIDTH-1:0]       cfg_data,
  output logic [CFG_AWIDTH-1:0]       cfg_addr,
  output logic                        cfg_valid,
  output logic [IMG_WIDTH-1:0]        image,
  output logic                        image_val,
  output logic                        busy,
  output logic                        done
);

  localparam int K_W = (KER_NB > 1) ? $clog2(KER_NB) : 1;
  localparam int S_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int G_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_W, S_CFG_K, S_CFG_R, S_SETTLE, S_STREAM, S_GAP, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [MEM_AWIDTH-1:0]       row_len_reg;
  logic [15:0]                 rows_reg;
  logic [KER_NB*KER_WIDTH-1:0] kernel_reg;
  logic [7:0]                  shift_reg;
  logic [7:0]                  head_reg;

  logic [K_W-1:0]        k_cnt_reg;
  logic [S_W-1:0]        settle_cnt_reg;
  logic [G_W-1:0]        gap_cnt_reg;
  logic [MEM_AWIDTH-1:0] col_cnt_reg;
  logic [15:0]           row_cnt_reg;

  logic [KER_WIDTH-1:0] coef [KER_NB];
  logic [KER_WIDTH-1:0] cur_coef;
  logic xfer, last_k, last_settle, last_gap, last_col, last_row, empty_frame;

  // Unpack the latched kernel so the write sequencer can index it by count.
  genvar gi;
  generate
    for (gi = 0; gi < KER_NB; gi++) begin : g_coef
      assign coef[gi] = kernel_reg[gi*KER_WIDTH +: KER_WIDTH];
    end
  endgenerate

  assign cur_coef    = coef[k_cnt_reg];
  assign xfer        = up_val && (state_reg == S_STREAM);
  assign last_k      = (k_cnt_reg == K_W'(KER_NB - 1));
  assign last_settle = (settle_cnt_reg == S_W'(SETTLE - 1));
  assign last_gap    = (gap_cnt_reg == G_W'(ROW_GAP - 1));
  assign last_col    = (col_cnt_reg == row_len_reg - 1'b1);
  assign last_row    = (row_cnt_reg == rows_reg - 16'd1);
  assign empty_frame = (row_len_reg == '0) || (rows_reg == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: config writes, settle, then row bursts separated by gaps.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_CFG_W;
      S_CFG_W:  state_next = S_CFG_K;
      S_CFG_K:  if (last_k) state_next = S_CFG_R;
      S_CFG_R:  state_next = S_SETTLE;
      S_SETTLE: if (last_settle) state_next = empty_frame ? S_DONE : S_STREAM;
      S_STREAM: begin
        if (xfer && last_col) begin
          if (last_row)          state_next = S_DONE;
          else if (ROW_GAP != 0) state_next = S_GAP;
        end
      end
      S_GAP:    if (last_gap) state_next = S_STREAM;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode: outputs depend only on flops; config bus is zero when idle.
  always_comb begin
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    up_rdy    = 1'b0;
    busy      = (state_reg != S_IDLE);
    done      = (state_reg == S_DONE);
    case (state_reg)
      S_CFG_W: begin
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(1);
        cfg_data  = CFG_DWIDTH'(row_len_reg);
      end
      S_CFG_K: begin
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(2);
        cfg_data  = {{(CFG_DWIDTH-KER_WIDTH){cur_coef[KER_WIDTH-1]}}, cur_coef};
      end
      S_CFG_R: begin
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(3);
        cfg_data  = CFG_DWIDTH'({shift_reg, head_reg});
      end
      S_STREAM: up_rdy = 1'b1;
      default: ;
    endcase
  end

  // Frame descriptor is captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_len_reg <= '0;
      rows_reg    <= '0;
      kernel_reg  <= '0;
      shift_reg   <= '0;
      head_reg    <= '0;
    end else if (state_reg == S_IDLE && start) begin
      row_len_reg <= frm_row_len;
      rows_reg    <= frm_rows;
      kernel_reg  <= frm_kernel;
      shift_reg   <= frm_shift;
      head_reg    <= frm_head;
    end
  end

  // Phase counters clear outside their phase; column/row advance on transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cnt_reg      <= '0;
      settle_cnt_reg <= '0;
      gap_cnt_reg    <= '0;
      col_cnt_reg    <= '0;
      row_cnt_reg    <= '0;
    end else begin
      k_cnt_reg      <= (state_reg == S_CFG_K)  ? k_cnt_reg + 1'b1      : '0;
      settle_cnt_reg <= (state_reg == S_SETTLE) ? settle_cnt_reg + 1'b1 : '0;
      gap_cnt_reg    <= (state_reg == S_GAP)    ? gap_cnt_reg + 1'b1    : '0;
      if (state_reg == S_IDLE) begin
        col_cnt_reg <= '0;
        row_cnt_reg <= '0;
      end else if (xfer) begin
        if (last_col) begin
          col_cnt_reg <= '0;
          row_cnt_reg <= row_cnt_reg + 16'd1;
        end else begin
          col_cnt_reg <= col_cnt_reg + 1'b1;
        end
      end
    end
  end

  // One-cycle pixel pipeline into the filter; image reads 0 between pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_val <= 1'b0;
      image     <= '0;
    end else begin
      image_val <= xfer;
      image     <= xfer ? up_data : '0;
    end
  end

endmodule

// File: tb/tb_stream_filter_feeder.sv
`timescale 1ns/1ps
// Directed bench for stream_filter_feeder: cycle-by-cycle checks of config
// writes, pixel pacing, stalls, ignored starts, degenerate frames and reset.
module tb_stream_filter_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [11:0]  frm_row_len;
  logic [15:0]  frm_rows;
  logic [143:0] frm_kernel;
  logic [7:0]   frm_shift;
  logic [7:0]   frm_head;
  logic [15:0]  up_data;
  logic         up_val;
  logic         up_rdy;
  logic [31:0]  cfg_data;
  logic [4:0]   cfg_addr;
  logic         cfg_valid;
  logic [15:0]  image;
  logic         image_val;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  logic [15:0] cur_kern [9];
  logic [11:0] cur_len;
  logic [7:0]  cur_shift;
  logic [7:0]  cur_head;
  logic [15:0] kern2 [9] = '{16'hFFFE, 16'h7FFF, 16'h8001, 16'h0003, 16'h0004,
                             16'h0005, 16'h0006, 16'h0007, 16'h0008};

  stream_filter_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frm_row_len(frm_row_len), .frm_rows(frm_rows), .frm_kernel(frm_kernel),
    .frm_shift(frm_shift), .frm_head(frm_head),
    .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .image(image), .image_val(image_val), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected config bus for cycle c of a frame that started at cycle 0.
  task automatic chk_cfg(input string nm, input int c);
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    v = (c >= 1 && c <= 11);
    a = 5'd0;
    d = 32'd0;
    if (c == 1) begin
      a = 5'd1; d = 32'(cur_len);
    end else if (c >= 2 && c <= 10) begin
      a = 5'd2; d = {{16{cur_kern[c-2][15]}}, cur_kern[c-2]};
    end else if (c == 11) begin
      a = 5'd3; d = {16'h0000, cur_shift, cur_head};
    end
    chk($sformatf("%s c%0d cfg_valid", nm, c), 32'(cfg_valid), 32'(v));
    chk($sformatf("%s c%0d cfg_addr", nm, c), 32'(cfg_addr), 32'(a));
    chk($sformatf("%s c%0d cfg_data", nm, c), cfg_data, d);
  endtask

  task automatic setup_frame(input logic [11:0] len, input logic [15:0] rows,
                             input logic [7:0] sh, input logic [7:0] hd);
    cur_len = len; cur_shift = sh; cur_head = hd;
    frm_row_len = len; frm_rows = rows; frm_shift = sh; frm_head = hd;
    for (int k = 0; k < 9; k++) frm_kernel[k*16 +: 16] = cur_kern[k];
  endtask

  function automatic bit rdy_def(input int c);
    return (c >= 16 && c <= 19) || (c >= 22 && c <= 25) || (c >= 28 && c <= 31);
  endfunction

  // Default frame: 4x3, kernel 1..9, shift 8, head 0, source always valid.
  task automatic run_default(input string nm);
    for (int k = 0; k < 9; k++) cur_kern[k] = 16'(k + 1);
    setup_frame(12'd4, 16'd3, 8'd8, 8'd0);
    up_val = 1'b1;
    up_data = 16'h0100;
    start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      start = 1'b0;
      up_data = 16'h0100 + 16'(c);
      chk_cfg(nm, c);
      chk($sformatf("%s c%0d up_rdy", nm, c), 32'(up_rdy), 32'(rdy_def(c)));
      chk($sformatf("%s c%0d image_val", nm, c), 32'(image_val), 32'(rdy_def(c-1)));
      chk($sformatf("%s c%0d image", nm, c), 32'(image),
          rdy_def(c-1) ? 32'(16'h0100 + 16'(c-1)) : 32'd0);
      chk($sformatf("%s c%0d done", nm, c), 32'(done), 32'(c == 32));
      chk($sformatf("%s c%0d busy", nm, c), 32'(busy), 32'(c <= 32));
    end
    $display("[TB] frame %s: 4x3 default frame checked", nm);
  endtask

  initial begin
    int act;
    bit rdy2, xf_prev;
    rst_n = 1'b0; start = 1'b0; up_val = 1'b0; up_data = '0;
    frm_row_len = '0; frm_rows = '0; frm_kernel = '0; frm_shift = '0; frm_head = '0;
    for (int k = 0; k < 9; k++) cur_kern[k] = '0;
    cur_len = '0; cur_shift = '0; cur_head = '0;

    // Reset state
    tick(); tick(); tick();
    chk("rst cfg_valid", 32'(cfg_valid), 32'd0);
    chk("rst cfg_addr", 32'(cfg_addr), 32'd0);
    chk("rst cfg_data", cfg_data, 32'd0);
    chk("rst up_rdy", 32'(up_rdy), 32'd0);
    chk("rst image_val", 32'(image_val), 32'd0);
    chk("rst image", 32'(image), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle busy", 32'(busy), 32'd0);

    // Default frame
    run_default("dflt");

    // Negative coefficients, stalling source, start reasserted while busy.
    for (int k = 0; k < 9; k++) cur_kern[k] = kern2[k];
    setup_frame(12'd3, 16'd2, 8'h12, 8'h34);
    up_val = 1'b1;
    up_data = 16'h0200;
    start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      tick();
      start = (c == 5 || c == 20 || c == 29);
      up_val = (c % 2 == 0);
      up_data = 16'h0200 + 16'(c);
      rdy2 = (c >= 16 && c <= 20) || (c >= 23 && c <= 28);
      xf_prev = (c - 1 >= 16) && (c - 1 <= 28) && ((c - 1) % 2 == 0) && (c - 1 != 22);
      chk_cfg("stall", c);
      chk($sformatf("stall c%0d up_rdy", c), 32'(up_rdy), 32'(rdy2));
      chk($sformatf("stall c%0d image_val", c), 32'(image_val), 32'(xf_prev));
      chk($sformatf("stall c%0d image", c), 32'(image),
          xf_prev ? 32'(16'h0200 + 16'(c-1)) : 32'd0);
      chk($sformatf("stall c%0d done", c), 32'(done), 32'(c == 29));
      chk($sformatf("stall c%0d busy", c), 32'(busy), 32'(c <= 29));
    end
    $display("[TB] frame stall: 3x2 stalled frame with negative kernel checked");

    // Degenerate frame: zero row length.
    for (int k = 0; k < 9; k++) cur_kern[k] = 16'(k + 1);
    setup_frame(12'd0, 16'd2, 8'd8, 8'd0);
    up_val = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      start = 1'b0;
      chk_cfg("degen", c);
      chk($sformatf("degen c%0d up_rdy", c), 32'(up_rdy), 32'd0);
      chk($sformatf("degen c%0d image_val", c), 32'(image_val), 32'd0);
      chk($sformatf("degen c%0d done", c), 32'(done), 32'(c == 16));
      chk($sformatf("degen c%0d busy", c), 32'(busy), 32'(c <= 16));
    end
    $display("[TB] frame degen: zero-length frame checked");

    // Reset during kernel writes.
    for (int k = 0; k < 9; k++) cur_kern[k] = 16'(k + 1);
    setup_frame(12'd4, 16'd3, 8'd8, 8'd0);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin tick(); start = 1'b0; end
    chk("rstk pre cfg_valid", 32'(cfg_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstk cfg_valid", 32'(cfg_valid), 32'd0);
    chk("rstk cfg_addr", 32'(cfg_addr), 32'd0);
    chk("rstk cfg_data", cfg_data, 32'd0);
    chk("rstk busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    act = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      act += int'(cfg_valid) + int'(done) + int'(busy) + int'(image_val) + int'(up_rdy);
    end
    chk("rstk activity after release", 32'(act), 32'd0);

    // Reset during streaming.
    start = 1'b1;
    up_val = 1'b1;
    for (int c = 1; c <= 18; c++) begin tick(); start = 1'b0; up_data = 16'h0300 + 16'(c); end
    chk("rsts pre image_val", 32'(image_val), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rsts up_rdy", 32'(up_rdy), 32'd0);
    chk("rsts image_val", 32'(image_val), 32'd0);
    chk("rsts image", 32'(image), 32'd0);
    chk("rsts busy", 32'(busy), 32'd0);
    chk("rsts done", 32'(done), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    act = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      act += int'(cfg_valid) + int'(done) + int'(busy) + int'(image_val) + int'(up_rdy);
    end
    chk("rsts activity after release", 32'(act), 32'd0);

    // Clean frame after the resets.
    run_default("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
